// File: rtl/csr_timer_bank_pkg.sv
// csr_timer_bank_pkg: register indices, TCFG field positions and the CSR
// number range that the CSR file forwards to the timer bank.
package csr_timer_bank_pkg;

    // Register index within a channel: csr_addr[1:0]
    localparam logic [1:0] REG_TCFG  = 2'd0;
    localparam logic [1:0] REG_TVAL  = 2'd1;
    localparam logic [1:0] REG_TICLR = 2'd2;
    localparam logic [1:0] REG_PSC   = 2'd3;

    // TCFG field positions
    localparam int TCFG_EN        = 0;
    localparam int TCFG_PERIODIC  = 1;
    localparam int TCFG_INITV_LSB = 2;

    // Shared prescaler width
    localparam int PSC_W = 8;

    // CSR numbers for the bank: 8 channels x 4 registers max
    localparam logic [13:0] CSR_TBANK_BASE = 14'h0440;
    localparam logic [13:0] CSR_TBANK_LAST = 14'h045F;

    // CSR number of register 'r' in channel 'ch'
    function automatic logic [13:0] csr_tbank_num(input logic [2:0] ch, input logic [1:0] r);
        return CSR_TBANK_BASE + {9'd0, ch, r};
    endfunction

endpackage

// File: rtl/csr_timer_bank_channel.sv
// timer_channel: one countdown channel -- TCFG fields, counter and pending
// latch. The counter sits at all-ones when idle.
module timer_channel
    import csr_timer_bank_pkg::*;
#(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 wr_tcfg,
    input  logic [CNT_WIDTH-1:0] wmask,
    input  logic [CNT_WIDTH-1:0] wvalue,
    input  logic                 clr,
    input  logic                 tick,
    input  logic                 halt,
    output logic [CNT_WIDTH-1:0] tcfg_rd,
    output logic [CNT_WIDTH-1:0] cnt,
    output logic                 pending
);

    logic                 en_q, en_d;
    logic                 periodic_q, periodic_d;
    logic [CNT_WIDTH-3:0] initv_q, initv_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 pend_q, pend_d;
    logic [CNT_WIDTH-1:0] tcfg_new;
    logic                 counting;
    logic                 pend_set;

    assign tcfg_rd = {initv_q, periodic_q, en_q};
    assign cnt     = cnt_q;
    assign pending = pend_q;

    // Next-state: masked TCFG update, counter reload/decrement, pending latch
    always_comb begin
        tcfg_new   = (wmask & wvalue) | (~wmask & tcfg_rd);
        en_d       = en_q;
        periodic_d = periodic_q;
        initv_d    = initv_q;
        cnt_d      = cnt_q;
        counting   = en_q && (cnt_q != '1) && !halt && tick;
        pend_set   = en_q && (cnt_q == '0) && !halt && tick;

        if (wr_tcfg) begin
            en_d       = tcfg_new[TCFG_EN];
            periodic_d = tcfg_new[TCFG_PERIODIC];
            initv_d    = tcfg_new[CNT_WIDTH-1:TCFG_INITV_LSB];
        end

        // An enabling TCFG write restarts the count and beats counting
        if (wr_tcfg && tcfg_new[TCFG_EN]) begin
            cnt_d = {tcfg_new[CNT_WIDTH-1:TCFG_INITV_LSB], 2'b00};
        end else if (counting) begin
            if ((cnt_q == '0) && periodic_q)
                cnt_d = {initv_q, 2'b00};
            else
                cnt_d = cnt_q - 1'b1;  // one-shot falls 0 -> all-ones and stops
        end

        // Set wins over a same-cycle clear
        pend_d = pend_set | (pend_q & ~clr);
    end

    // State registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            en_q       <= 1'b0;
            periodic_q <= 1'b0;
            initv_q    <= '0;
            cnt_q      <= '1;
            pend_q     <= 1'b0;
        end else begin
            en_q       <= en_d;
            periodic_q <= periodic_d;
            initv_q    <= initv_d;
            cnt_q      <= cnt_d;
            pend_q     <= pend_d;
        end
    end

endmodule

// File: rtl/csr_timer_bank.sv
// csr_timer_bank: NUM_TIMERS countdown channels behind a masked-write CSR
// window, with a merged interrupt. Define TIMER_PRESCALE_EN to build the
// shared 8-bit prescaler (reg 3); otherwise every cycle is a tick.
module csr_timer_bank
    import csr_timer_bank_pkg::*;
#(
    parameter int NUM_TIMERS = 4,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                            clk,
    input  logic                            resetn,
    input  logic                            csr_re,
    input  logic [$clog2(NUM_TIMERS)+2-1:0] csr_addr,
    input  logic                            csr_we,
    input  logic [31:0]                     csr_wmask,
    input  logic [31:0]                     csr_wvalue,
    output logic [31:0]                     csr_rvalue,
    input  logic                            halt,
    output logic [NUM_TIMERS-1:0]           timer_pending,
    output logic                            timer_int
);

    localparam int AW  = $clog2(NUM_TIMERS) + 2;
    localparam int CHW = (AW > 2) ? AW - 2 : 1;

    logic [1:0]                            reg_sel;
    logic [CHW-1:0]                        ch_sel;
    logic                                  tick;
    logic [31:0]                           psc_rd;
    logic [NUM_TIMERS-1:0][CNT_WIDTH-1:0]  tcfg_rd;
    logic [NUM_TIMERS-1:0][CNT_WIDTH-1:0]  cnt;

    assign reg_sel = csr_addr[1:0];

    // Single-channel builds have no channel field in the address
    if (AW > 2) begin : g_chsel
        assign ch_sel = csr_addr[AW-1:2];
    end else begin : g_chsel0
        assign ch_sel = '0;
    end

`ifdef TIMER_PRESCALE_EN
    logic [PSC_W-1:0] psc_q, psc_d;
    logic [PSC_W-1:0] pre_q, pre_d;
    logic             psc_wr;

    assign psc_wr = csr_we && (reg_sel == REG_PSC);
    assign tick   = (pre_q == psc_q);
    assign psc_rd = {{(32-PSC_W){1'b0}}, psc_q};

    // Prescaler: free-running, restarts on tick or on any PSC write
    always_comb begin
        psc_d = psc_q;
        pre_d = pre_q;
        if (psc_wr) begin
            psc_d = (csr_wmask[PSC_W-1:0] & csr_wvalue[PSC_W-1:0]) |
                    (~csr_wmask[PSC_W-1:0] & psc_q);
            pre_d = '0;
        end else if (!halt) begin
            pre_d = tick ? '0 : pre_q + 1'b1;
        end
    end

    // Prescaler registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            psc_q <= '0;
            pre_q <= '0;
        end else begin
            psc_q <= psc_d;
            pre_q <= pre_d;
        end
    end
`else
    assign tick   = 1'b1;
    assign psc_rd = 32'd0;
`endif

    for (genvar i = 0; i < NUM_TIMERS; i++) begin : g_ch
        logic wr_tcfg;
        logic clr;

        assign wr_tcfg = csr_we && (reg_sel == REG_TCFG) && (ch_sel == CHW'(i));
        assign clr     = csr_we && (reg_sel == REG_TICLR) && (ch_sel == CHW'(i)) &&
                         csr_wmask[0] && csr_wvalue[0];

        timer_channel #(.CNT_WIDTH(CNT_WIDTH)) u_ch (
            .clk     (clk),
            .resetn  (resetn),
            .wr_tcfg (wr_tcfg),
            .wmask   (csr_wmask[CNT_WIDTH-1:0]),
            .wvalue  (csr_wvalue[CNT_WIDTH-1:0]),
            .clr     (clr),
            .tick    (tick),
            .halt    (halt),
            .tcfg_rd (tcfg_rd[i]),
            .cnt     (cnt[i]),
            .pending (timer_pending[i])
        );
    end

    assign timer_int = |timer_pending;

    // Read mux; out-of-range channels match no instance and read 0
    always_comb begin
        csr_rvalue = 32'd0;
        if (csr_re) begin
            for (int i = 0; i < NUM_TIMERS; i++) begin
                if (ch_sel == CHW'(i)) begin
                    case (reg_sel)
                        REG_TCFG: csr_rvalue = 32'(tcfg_rd[i]);
                        REG_TVAL: csr_rvalue = 32'(cnt[i]);
                        REG_PSC:  csr_rvalue = psc_rd;
                        default:  csr_rvalue = 32'd0;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_csr_timer_bank.sv
// Directed bench for csr_timer_bank: default 4x32 instance plus a 3x16
// instance for out-of-range channel and narrow-counter checks.
module tb_csr_timer_bank;

    logic        clk;
    logic        resetn;
    logic        halt;

    logic        csr_re, csr_we;
    logic [3:0]  csr_addr;
    logic [31:0] csr_wmask, csr_wvalue, csr_rvalue;
    logic [3:0]  timer_pending;
    logic        timer_int;

    logic        u1_re, u1_we;
    logic [3:0]  u1_addr;
    logic [31:0] u1_wmask, u1_wvalue, u1_rvalue;
    logic [2:0]  u1_pending;
    logic        u1_int;

    int tests = 0;
    int fails = 0;

    csr_timer_bank #(.NUM_TIMERS(4), .CNT_WIDTH(32)) u0 (
        .clk(clk), .resetn(resetn), .csr_re(csr_re), .csr_addr(csr_addr),
        .csr_we(csr_we), .csr_wmask(csr_wmask), .csr_wvalue(csr_wvalue),
        .csr_rvalue(csr_rvalue), .halt(halt), .timer_pending(timer_pending),
        .timer_int(timer_int)
    );

    csr_timer_bank #(.NUM_TIMERS(3), .CNT_WIDTH(16)) u1 (
        .clk(clk), .resetn(resetn), .csr_re(u1_re), .csr_addr(u1_addr),
        .csr_we(u1_we), .csr_wmask(u1_wmask), .csr_wvalue(u1_wvalue),
        .csr_rvalue(u1_rvalue), .halt(halt), .timer_pending(u1_pending),
        .timer_int(u1_int)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; the write lands on the following posedge
    task automatic wr(input logic [3:0] a, input logic [31:0] m, input logic [31:0] v);
        csr_addr = a; csr_wmask = m; csr_wvalue = v; csr_we = 1'b1;
        @(negedge clk);
        csr_we = 1'b0; csr_wmask = '0; csr_wvalue = '0;
    endtask

    task automatic rd(input logic [3:0] a, output logic [31:0] d);
        csr_addr = a; csr_re = 1'b1;
        #1 d = csr_rvalue;
        csr_re = 1'b0;
    endtask

    task automatic wr1(input logic [3:0] a, input logic [31:0] m, input logic [31:0] v);
        u1_addr = a; u1_wmask = m; u1_wvalue = v; u1_we = 1'b1;
        @(negedge clk);
        u1_we = 1'b0; u1_wmask = '0; u1_wvalue = '0;
    endtask

    task automatic rd1(input logic [3:0] a, output logic [31:0] d);
        u1_addr = a; u1_re = 1'b1;
        #1 d = u1_rvalue;
        u1_re = 1'b0;
    endtask

    initial begin
        logic [31:0] d;
        int per_seq [5] = '{3, 2, 1, 0, 4};

        resetn = 1'b0; halt = 1'b0;
        csr_re = 0; csr_we = 0; csr_addr = '0; csr_wmask = '0; csr_wvalue = '0;
        u1_re = 0; u1_we = 0; u1_addr = '0; u1_wmask = '0; u1_wvalue = '0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;

        // Reset state
        rd(4'h1, d); chk("rst_tval_ch0", d, 32'hFFFF_FFFF);
        rd(4'hD, d); chk("rst_tval_ch3", d, 32'hFFFF_FFFF);
        rd(4'h0, d); chk("rst_tcfg_ch0", d, 32'h0);
        chk("rst_int", timer_int, 1'b0);
        chk("rst_pending", timer_pending, 4'h0);

        // Ch0 one-shot, INITV=2: 8..0 then idle
        wr(4'h0, 32'hFFFF_FFFF, 32'h9);
        rd(4'h1, d); chk("os_tval_8", d, 32'd8);
        for (int k = 7; k >= 0; k--) begin
            @(negedge clk);
            rd(4'h1, d); chk("os_tval", d, k);
        end
        chk("os_pend_pre", timer_pending, 4'h0);
        @(negedge clk);
        chk("os_pend_set", timer_pending, 4'h1);
        chk("os_int", timer_int, 1'b1);
        rd(4'h1, d); chk("os_idle", d, 32'hFFFF_FFFF);
        repeat (3) @(negedge clk);
        rd(4'h1, d); chk("os_idle_stays", d, 32'hFFFF_FFFF);
        chk("os_pend_held", timer_pending, 4'h1);
        rd(4'h0, d); chk("os_tcfg_rd", d, 32'h9);
        rd(4'h2, d); chk("ticlr_rd0", d, 32'h0);
        wr(4'h2, 32'h1, 32'h1);
        chk("os_pend_clr", timer_pending, 4'h0);
        chk("os_int_clr", timer_int, 1'b0);

        // Ch2 periodic, INITV=1: 4,3,2,1,0,4,...
        wr(4'h8, 32'hFFFF_FFFF, 32'h7);
        rd(4'h9, d); chk("per_tval_4", d, 32'd4);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            rd(4'h9, d); chk("per_seq", d, per_seq[k]);
        end
        chk("per_pend_set", timer_pending, 4'h4);
        wr(4'hA, 32'h1, 32'h1);
        rd(4'h9, d); chk("per_tval_3", d, 32'd3);
        chk("per_pend_clr", timer_pending, 4'h0);
        repeat (3) @(negedge clk);
        rd(4'h9, d); chk("per_tval_0", d, 32'd0);
        wr(4'hA, 32'h1, 32'h1);   // clear lands on the set cycle
        chk("set_wins", timer_pending, 4'h4);
        rd(4'h9, d); chk("per_reload", d, 32'd4);

        // Masked TCFG write touching only EN: reload from the old INITV
        @(negedge clk);
        rd(4'h9, d); chk("mask_pre", d, 32'd3);
        wr(4'h8, 32'h1, 32'h31);
        rd(4'h9, d); chk("mask_reload", d, 32'd4);
        rd(4'h8, d); chk("mask_tcfg", d, 32'h7);

        // Halt: counter frozen, clears still act
        halt = 1'b1;
        wr(4'hA, 32'h1, 32'h1);
        chk("halt_clr", timer_pending, 4'h0);
        repeat (9) @(negedge clk);
        rd(4'h9, d); chk("halt_frozen", d, 32'd4);
        halt = 1'b0;
        @(negedge clk);
        rd(4'h9, d); chk("halt_resume", d, 32'd3);

        // Asynchronous reset mid-count
        repeat (4) @(negedge clk);
        chk("mid_int_pre", timer_int, 1'b1);
        resetn = 1'b0;
        #1;
        chk("mid_rst_int", timer_int, 1'b0);
        rd(4'h9, d); chk("mid_rst_tval", d, 32'hFFFF_FFFF);
        rd(4'h8, d); chk("mid_rst_tcfg", d, 32'h0);
        @(negedge clk);
        resetn = 1'b1;

`ifdef TIMER_PRESCALE_EN
        // PSC=3: one count every 4 cycles
        wr(4'h3, 32'hFF, 32'h3);
        rd(4'h7, d); chk("psc_rd", d, 32'h3);
        wr(4'h0, 32'hFFFF_FFFF, 32'h5);
        rd(4'h1, d); chk("psc_t0", d, 32'd4);
        repeat (2) @(negedge clk);
        rd(4'h1, d); chk("psc_t2", d, 32'd4);
        @(negedge clk);
        rd(4'h1, d); chk("psc_t3", d, 32'd3);
        repeat (3) @(negedge clk);
        rd(4'h1, d); chk("psc_t6", d, 32'd3);
        @(negedge clk);
        rd(4'h1, d); chk("psc_t7", d, 32'd2);
`else
        wr(4'h3, 32'hFFFF_FFFF, 32'h3);
        rd(4'h3, d); chk("psc_absent_ch0", d, 32'h0);
        rd(4'h7, d); chk("psc_absent_ch1", d, 32'h0);
`endif

        // 3-channel, 16-bit instance: channel 3 is out of range
        wr1(4'hC, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        rd1(4'hC, d); chk("oor_rd", d, 32'h0);
        rd1(4'h0, d); chk("oor_ch0_tcfg", d, 32'h0);
        rd1(4'h8, d); chk("oor_ch2_tcfg", d, 32'h0);
        rd1(4'h1, d); chk("oor_ch0_tval", d, 32'h0000_FFFF);
        chk("oor_int", u1_int, 1'b0);
        wr1(4'h4, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        rd1(4'h4, d); chk("w16_tcfg", d, 32'h0000_FFFE);
        rd1(4'h5, d); chk("w16_tval_hold", d, 32'h0000_FFFF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
